wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back end of the integer pipeline. Takes the retiring MEM/WB bundle (`reg_write`, `reg_dst`, `mem_reg_dst`, instruction, ALU result, memory data) and writes the selected result into a 32-entry register file. Serves the two ID-stage read ports that feed the ID/EX register. Keeps a per-register pending-write scoreboard that raises `stall` to ID while a source register still has a write in flight.

## Interface
Parameters:
- `DATA_W`, 32, register and datapath width.
- `PEND_W`, 2, width of each pending-write counter; maximum count is 2^PEND_W-1.

Ports:
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  reset, synchronous, active-high.
- `rs_addr`  in  5  ID read address A (instr[25:21]).
- `rt_addr`  in  5  ID read address B (instr[20:16]).
- `rs_data`  out  DATA_W  read data A, combinational.
- `rt_data`  out  DATA_W  read data B, combinational.
- `issue_valid`  in  1  ID hands an instruction to ID/EX this cycle.
- `issue_reg_write`  in  1  the issued instruction writes a register.
- `issue_dest`  in  5  destination of the issued instruction, already resolved for `reg_dst`.
- `wb_valid`  in  1  MEM/WB bundle valid.
- `wb_reg_write`  in  1  retiring instruction writes a register.
- `wb_reg_dst`  in  1  destination select: 1 = instr[15:11], 0 = instr[20:16].
- `wb_mem_reg_dst`  in  1  data select: 1 = `wb_mem_data`, 0 = `wb_alu_result`.
- `wb_instr`  in  32  retiring instruction word.
- `wb_alu_result`  in  DATA_W  EX result.
- `wb_mem_data`  in  DATA_W  load data.
- `stall`  out  1  ID must hold; combinational.
- `sb_error`  out  1  sticky scoreboard over/underflow flag.

## Operation
- Write enable: `we = wb_valid & wb_reg_write & (wb_dest != 0)`.
- Destination: `wb_dest = wb_reg_dst ? wb_instr[15:11] : wb_instr[20:16]`.
- Write data: `wb_data = wb_mem_reg_dst ? wb_mem_data : wb_alu_result`, full DATA_W, no extension.
- Register 0 is never written and always reads 0. The scoreboard never counts register 0.
- Reads are asynchronous from array state (plus bypass, see Configuration).
- Scoreboard, one `pend[r]` counter per register, PEND_W bits:
  - inc: `issue_valid & issue_reg_write & issue_dest != 0`
  - dec: `we`
  - inc and dec on the same register in the same cycle: unchanged.
  - inc at max count: saturate, set `sb_error`.
  - dec at 0: hold 0, set `sb_error`.
- `stall = (rs_addr != 0 & rs_hazard) | (rt_addr != 0 & rt_hazard)`.
  - `x_hazard` is `pend[x] != 0`, modified by the macro below.
- ID is required to drive `issue_valid` = 0 while `stall` = 1. The block does not gate `issue_valid` itself.
- `sb_error` clears only on reset.

## Timing
- Reset values: all 31 registers 0, all `pend` 0, `sb_error` 0. Therefore `rs_data`, `rt_data` and `stall` are 0 the cycle after reset.
- Reset during an in-flight write discards the write. Reset wins over all other updates.
- Write latency: data is in the array at the posedge where `we` = 1. It is visible without bypass from the following cycle.
- Scoreboard latency: `pend` updates at the same posedge. `stall` reflects the new count in the following cycle.
- No handshake backpressure on the WB side: a valid retiring bundle is always accepted.

## Configuration
- `WB_REGFILE_BYPASS_EN` defined:
  - A read whose address equals `wb_dest` while `we` = 1 returns `wb_data` combinationally.
  - For that register, `x_hazard = (pend[x] > 1)`, so the last pending write completing this cycle releases the stall one cycle early.
- Not defined:
  - Reads return array contents only.
  - `x_hazard = (pend[x] != 0)`, so ID stalls through the write cycle and resumes the cycle after.

## Structure
- Shared pipeline package holds:
  - `REG_ADDR_W` = 5, `NUM_REGS` = 32.
  - Field-slice constants `RS_LSB` = 21, `RT_LSB` = 16, `RD_LSB` = 11.
  - Typedef for the MEM/WB control bundle (`reg_write`, `reg_dst`, `mem_reg_dst`).
- One natural sub-module: `wb_scoreboard` (counters, saturation/underflow, `sb_error`). Register array, bypass and `stall` stay in the top.

## Test plan
- Reset, then read rs = 5, rt = 31 -> both 0, `stall` = 0, `sb_error` = 0.
- WB `wb_reg_dst` = 1, instr[15:11] = 8, `wb_mem_reg_dst` = 0, alu = 0xDEADBEEF -> next cycle `rs_addr` = 8 reads 0xDEADBEEF. Repeat with `wb_mem_reg_dst` = 1, mem = 0x12345678 -> reads 0x12345678.
- Write to r0 with alu = 0xFFFFFFFF -> r0 still reads 0; `pend` unchanged; no stall on r0.
- Issue dest = 3, then `rs_addr` = 3 -> `stall` = 1. When WB writes r3 = 0x55:
  - with `WB_REGFILE_BYPASS_EN`: `stall` = 0 and `rs_data` = 0x55 in that same cycle.
  - without: `stall` = 1 that cycle, `stall` = 0 and `rs_data` = 0x55 the next cycle.
- Issue to r4 and WB retire of r4 in the same cycle with `pend[4]` = 1 -> `pend[4]` stays 1, `stall` on r4 stays 1, `sb_error` = 0.
- WB retire to r9 with `pend[9]` = 0 -> `sb_error` = 1 and stays set. Four issues to r10 with PEND_W = 2 -> saturates at 3, `sb_error` = 1. Reset -> `sb_error` = 0, all counters 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared pipeline constants and the MEM/WB control bundle
package wb_regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;
    typedef struct packed {
        logic reg_write;
        logic reg_dst;
        logic mem_reg_dst;
    } memwb_ctrl_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending-write counters with sticky over/underflow flag
module wb_scoreboard import wb_regfile_pkg::*; #(
    parameter int PEND_W = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                inc_en,
    input  logic [REG_ADDR_W-1:0]               inc_addr,
    input  logic                                dec_en,
    input  logic [REG_ADDR_W-1:0]               dec_addr,
    output logic [NUM_REGS-1:0][PEND_W-1:0]     pend,
    output logic                                sb_error
);
    logic same;
    assign same = inc_en && dec_en && inc_addr == dec_addr;
    // r0 is never counted, so the loop starts at 1
    always_ff @(posedge clock)
        if (reset) begin
            pend <= '0;
            sb_error <= 1'b0;
        end else
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc_en && !same && inc_addr == REG_ADDR_W'(r)) begin
                    if (pend[r] == '1) sb_error <= 1'b1;
                    else pend[r] <= pend[r] + 1'b1;
                end
                if (dec_en && !same && dec_addr == REG_ADDR_W'(r)) begin
                    if (pend[r] == '0) sb_error <= 1'b1;
                    else pend[r] <= pend[r] - 1'b1;
                end
            end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage, 32-entry register file, ID read ports and hazard stall.
// Define WB_REGFILE_BYPASS_EN to forward the retiring write to the read ports.
module wb_regfile import wb_regfile_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int PEND_W = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    input  logic                  issue_valid,
    input  logic                  issue_reg_write,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    input  logic                  wb_valid,
    input  logic                  wb_reg_write,
    input  logic                  wb_reg_dst,
    input  logic                  wb_mem_reg_dst,
    input  logic [31:0]           wb_instr,
    input  logic [DATA_W-1:0]     wb_alu_result,
    input  logic [DATA_W-1:0]     wb_mem_data,
    output logic                  stall,
    output logic                  sb_error
);
`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    memwb_ctrl_t ctrl;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic we, issue_inc, rs_byp, rt_byp, rs_hazard, rt_hazard, unused_instr;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0][PEND_W-1:0] pend;
    assign ctrl = '{reg_write: wb_reg_write, reg_dst: wb_reg_dst, mem_reg_dst: wb_mem_reg_dst};
    assign wb_dest = ctrl.reg_dst ? wb_instr[RD_LSB +: REG_ADDR_W] : wb_instr[RT_LSB +: REG_ADDR_W];
    assign wb_data = ctrl.mem_reg_dst ? wb_mem_data : wb_alu_result;
    assign we = wb_valid && ctrl.reg_write && wb_dest != '0;
    assign issue_inc = issue_valid && issue_reg_write && issue_dest != '0;
    assign unused_instr = ^{wb_instr[31:RS_LSB], wb_instr[RD_LSB-1:0]};
    always_ff @(posedge clock)
        if (reset)
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        else if (we)
            regs[wb_dest] <= wb_data;
    // a bypassed read sees the retiring write, so only a further pending write still blocks
    always_comb begin
        rs_byp = BYPASS && we && rs_addr == wb_dest;
        rt_byp = BYPASS && we && rt_addr == wb_dest;
        rs_data = rs_addr == '0 ? '0 : rs_byp ? wb_data : regs[rs_addr];
        rt_data = rt_addr == '0 ? '0 : rt_byp ? wb_data : regs[rt_addr];
        rs_hazard = rs_byp ? pend[rs_addr] > PEND_W'(1) : pend[rs_addr] != '0;
        rt_hazard = rt_byp ? pend[rt_addr] > PEND_W'(1) : pend[rt_addr] != '0;
        stall = (rs_addr != '0 && rs_hazard) || (rt_addr != '0 && rt_hazard);
    end
    wb_scoreboard #(.PEND_W(PEND_W)) u_sb (
        .clock    (clock),
        .reset    (reset),
        .inc_en   (issue_inc),
        .inc_addr (issue_dest),
        .dec_en   (we),
        .dec_addr (wb_dest),
        .pend     (pend),
        .sb_error (sb_error)
    );
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against a behavioural model
module tb_wb_regfile;
    localparam int DATA_W = 32;
    localparam int PEND_W = 2;
    localparam int PMAX = 3;
`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [4:0] rs_addr = '0, rt_addr = '0, issue_dest = '0;
    logic [DATA_W-1:0] rs_data, rt_data, wb_alu_result = '0, wb_mem_data = '0;
    logic issue_valid = 0, issue_reg_write = 0, wb_valid = 0, wb_reg_write = 0;
    logic wb_reg_dst = 0, wb_mem_reg_dst = 0, stall, sb_error;
    logic [31:0] wb_instr = '0;
    int vectors = 0, miscompares = 0;
    logic [31:0] m_regs [32];
    int m_pend [32];
    bit m_err;

    always #5 clock = ~clock;

    wb_regfile #(.DATA_W(DATA_W), .PEND_W(PEND_W)) dut (
        .clock(clock), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .issue_valid(issue_valid),
        .issue_reg_write(issue_reg_write), .issue_dest(issue_dest), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_reg_dst(wb_reg_dst), .wb_mem_reg_dst(wb_mem_reg_dst),
        .wb_instr(wb_instr), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .stall(stall), .sb_error(sb_error)
    );

    function automatic logic [4:0] cur_dest();
        return wb_reg_dst ? wb_instr[15:11] : wb_instr[20:16];
    endfunction
    function automatic bit cur_we();
        return wb_valid && wb_reg_write && cur_dest() != 0;
    endfunction
    function automatic logic [31:0] cur_data();
        return wb_mem_reg_dst ? wb_mem_data : wb_alu_result;
    endfunction
    function automatic bit exp_hazard(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (BYP && cur_we() && a == cur_dest()) return m_pend[a] > 1;
        return m_pend[a] != 0;
    endfunction
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (BYP && cur_we() && a == cur_dest()) return cur_data();
        return m_regs[a];
    endfunction

    task automatic cycle();
        logic [4:0] d;
        bit we, inc, same;
        @(posedge clock);
        d = cur_dest();
        we = cur_we();
        inc = issue_valid && issue_reg_write && issue_dest != 0;
        same = we && inc && d == issue_dest;
        if (reset) begin
            foreach (m_regs[i]) begin
                m_regs[i] = '0;
                m_pend[i] = 0;
            end
            m_err = 0;
        end else begin
            if (inc && !same) begin
                if (m_pend[issue_dest] == PMAX) m_err = 1;
                else m_pend[issue_dest]++;
            end
            if (we && !same) begin
                if (m_pend[d] == 0) m_err = 1;
                else m_pend[d]--;
            end
            if (we) m_regs[d] = cur_data();
        end
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_reg_write = 0; issue_dest = '0;
        wb_valid = 0; wb_reg_write = 0; wb_reg_dst = 0; wb_mem_reg_dst = 0;
        wb_instr = $urandom; wb_alu_result = $urandom; wb_mem_data = $urandom;
    endtask

    task automatic do_issue(input logic [4:0] d);
        issue_valid = 1; issue_reg_write = 1; issue_dest = d;
    endtask

    task automatic do_wb(input logic [4:0] d, input bit rd_sel, input bit mem_sel, input logic [31:0] val);
        wb_valid = 1; wb_reg_write = 1; wb_reg_dst = rd_sel; wb_mem_reg_dst = mem_sel;
        wb_instr = $urandom;
        if (rd_sel) wb_instr[15:11] = d;
        else wb_instr[20:16] = d;
        wb_alu_result = mem_sel ? $urandom : val;
        wb_mem_data = mem_sel ? val : $urandom;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
        rs_addr = 5; rt_addr = 31;
        #1;
        vectors++; if (rs_data !== 32'h0) begin miscompares++; $display("FAIL reset_rs: got %h want 0", rs_data); end
        vectors++; if (rt_data !== 32'h0) begin miscompares++; $display("FAIL reset_rt: got %h want 0", rt_data); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall); end
        vectors++; if (sb_error !== 1'b0) begin miscompares++; $display("FAIL reset_sb_error: got %b want 0", sb_error); end
    endtask

    task automatic test_write();
        idle(); rs_addr = 0; rt_addr = 0;
        do_issue(8); cycle(); idle();
        do_wb(8, 1, 0, 32'hDEADBEEF); cycle(); idle();
        rs_addr = 8;
        #1;
        vectors++; if (rs_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL write_alu: got %h want deadbeef", rs_data); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL write_alu_stall: got %b want 0", stall); end
        rs_addr = 0;
        do_issue(8); cycle(); idle();
        do_wb(8, 1, 1, 32'h12345678); cycle(); idle();
        rt_addr = 8;
        #1;
        vectors++; if (rt_data !== 32'h12345678) begin miscompares++; $display("FAIL write_mem: got %h want 12345678", rt_data); end
        vectors++; if (sb_error !== 1'b0) begin miscompares++; $display("FAIL write_sb_error: got %b want 0", sb_error); end
    endtask

    task automatic test_r0();
        idle(); rs_addr = 0; rt_addr = 0;
        do_wb(0, 1, 0, 32'hFFFFFFFF); cycle(); idle();
        #1;
        vectors++; if (rs_data !== 32'h0) begin miscompares++; $display("FAIL r0_read: got %h want 0", rs_data); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL r0_stall: got %b want 0", stall); end
        vectors++; if (sb_error !== 1'b0) begin miscompares++; $display("FAIL r0_sb_error: got %b want 0", sb_error); end
    endtask

    task automatic test_hazard();
        idle(); rs_addr = 0; rt_addr = 0;
        do_issue(3); cycle(); idle();
        rs_addr = 3;
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL hazard_pending: got %b want 1", stall); end
        do_wb(3, 0, 0, 32'h55);
        #1;
        vectors++; if (stall !== !BYP) begin miscompares++; $display("FAIL hazard_wb_cycle_stall: got %b want %b", stall, !BYP); end
        vectors++; if (rs_data !== (BYP ? 32'h55 : 32'h0)) begin miscompares++; $display("FAIL hazard_wb_cycle_data: got %h want %h", rs_data, BYP ? 32'h55 : 32'h0); end
        cycle(); idle();
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL hazard_after_stall: got %b want 0", stall); end
        vectors++; if (rs_data !== 32'h55) begin miscompares++; $display("FAIL hazard_after_data: got %h want 55", rs_data); end
    endtask

    task automatic test_same_cycle();
        idle(); rs_addr = 0; rt_addr = 0;
        do_issue(4); cycle();
        do_issue(4); do_wb(4, 1, 0, 32'hA4A4A4A4); cycle(); idle();
        rs_addr = 4;
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL same_cycle_stall: got %b want 1", stall); end
        vectors++; if (sb_error !== 1'b0) begin miscompares++; $display("FAIL same_cycle_sb_error: got %b want 0", sb_error); end
        vectors++; if (rs_data !== 32'hA4A4A4A4) begin miscompares++; $display("FAIL same_cycle_data: got %h want a4a4a4a4", rs_data); end
        rs_addr = 0;
        do_wb(4, 0, 1, 32'h44); cycle(); idle();
        rs_addr = 4;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL same_cycle_release: got %b want 0", stall); end
    endtask

    task automatic test_random();
        logic [65:0] exp;
        for (int n = 0; n < 300; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            wb_valid = 1'($urandom); wb_reg_write = 1'($urandom);
            wb_reg_dst = 1'($urandom); wb_mem_reg_dst = 1'($urandom);
            wb_instr = $urandom;
            wb_instr[15:11] = 5'($urandom_range(0, 7));
            wb_instr[20:16] = 5'($urandom_range(0, 7));
            wb_alu_result = $urandom; wb_mem_data = $urandom;
            rs_addr = 5'($urandom_range(0, 7)); rt_addr = 5'($urandom_range(0, 7));
            issue_reg_write = 1'($urandom); issue_dest = 5'($urandom_range(0, 7));
            issue_valid = !(exp_hazard(rs_addr) || exp_hazard(rt_addr)) && 1'($urandom);
            #1;
            exp = {exp_read(rs_addr), exp_read(rt_addr), exp_hazard(rs_addr) || exp_hazard(rt_addr), m_err};
            vectors++;
            if ({rs_data, rt_data, stall, sb_error} !== exp) begin
                miscompares++;
                $display("FAIL random[%0d]: rs=%h rt=%h stall=%b err=%b want rs=%h rt=%h stall=%b err=%b",
                         n, rs_data, rt_data, stall, sb_error, exp[65:34], exp[33:2], exp[1], exp[0]);
            end
            cycle();
        end
        reset = 0;
    endtask

    task automatic test_errors();
        idle(); rs_addr = 0; rt_addr = 0;
        reset = 1; cycle(); reset = 0;
        do_wb(9, 0, 0, $urandom); cycle(); idle();
        #1;
        vectors++; if (sb_error !== 1'b1) begin miscompares++; $display("FAIL underflow_set: got %b want 1", sb_error); end
        cycle(); cycle();
        vectors++; if (sb_error !== 1'b1) begin miscompares++; $display("FAIL underflow_sticky: got %b want 1", sb_error); end
        reset = 1; cycle(); reset = 0;
        for (int i = 0; i < 3; i++) begin do_issue(10); cycle(); end
        idle();
        vectors++; if (sb_error !== 1'b0) begin miscompares++; $display("FAIL count_at_max: got %b want 0", sb_error); end
        do_issue(10); cycle(); idle();
        rt_addr = 10;
        #1;
        vectors++; if (sb_error !== 1'b1) begin miscompares++; $display("FAIL overflow_set: got %b want 1", sb_error); end
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL overflow_stall: got %b want 1", stall); end
        rt_addr = 0;
        for (int i = 0; i < 2; i++) begin do_wb(10, 1, 0, $urandom); cycle(); end
        idle(); rt_addr = 10;
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL saturate_one_left: got %b want 1", stall); end
        rt_addr = 0;
        do_wb(10, 1, 0, $urandom); cycle(); idle();
        rt_addr = 10;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL saturate_drained: got %b want 0", stall); end
        rt_addr = 0;
        do_issue(10); do_wb(12, 1, 0, 32'hCAFEF00D);
        reset = 1; cycle(); reset = 0; idle();
        rs_addr = 12; rt_addr = 10;
        #1;
        vectors++; if (sb_error !== 1'b0) begin miscompares++; $display("FAIL reset_clears_error: got %b want 0", sb_error); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_clears_pend: got %b want 0", stall); end
        vectors++; if (rs_data !== 32'h0) begin miscompares++; $display("FAIL reset_discards_write: got %h want 0", rs_data); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_r0();
        test_hazard();
        test_same_cycle();
        test_random();
        test_errors();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
